// File: rtl/sigma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sigma_bus_arbiter
// Purpose : Two-master / one-slave sigma bus arbiter that routes in-order read
//           responses back to the master that issued each read.
// Revision: 1.0 - initial release
// ============================================================================
module sigma_bus_arbiter #(
  parameter int    ADDR_W        = 32,
  parameter int    DATA_W        = 32,
  parameter int    RD_FIFO_DEPTH = 4,
  parameter string PRIORITY      = "ROUND_ROBIN"
) (
  input  logic                           clk_i,
  input  logic                           arst_i,

  input  logic                           m0_req_i,
  input  logic                           m0_we_i,
  input  logic [ADDR_W-1:0]              m0_addr_i,
  input  logic [DATA_W/8-1:0]            m0_be_i,
  input  logic [DATA_W-1:0]              m0_wdata_i,
  output logic                           m0_ack_o,
  output logic                           m0_resp_o,
  output logic [DATA_W-1:0]              m0_rdata_o,

  input  logic                           m1_req_i,
  input  logic                           m1_we_i,
  input  logic [ADDR_W-1:0]              m1_addr_i,
  input  logic [DATA_W/8-1:0]            m1_be_i,
  input  logic [DATA_W-1:0]              m1_wdata_i,
  output logic                           m1_ack_o,
  output logic                           m1_resp_o,
  output logic [DATA_W-1:0]              m1_rdata_o,

  output logic                           s_req_o,
  output logic                           s_we_o,
  output logic [ADDR_W-1:0]              s_addr_o,
  output logic [DATA_W/8-1:0]            s_be_o,
  output logic [DATA_W-1:0]              s_wdata_o,
  input  logic                           s_ack_i,
  input  logic                           s_resp_i,
  input  logic [DATA_W-1:0]              s_rdata_i,

  output logic [$clog2(RD_FIFO_DEPTH):0] rd_pending_o,
  output logic                           err_o
);

  localparam int PTR_W    = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam bit M1_FIRST = (PRIORITY == "M1_FIRST");

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                   state;
  logic                     owner;
  logic                     last_grant;

  logic [RD_FIFO_DEPTH-1:0] id_mem;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     err;

  logic fifo_full;
  logic fifo_empty;
  logic elig0;
  logic elig1;
  logic winner;
  logic sel;
  logic bus_req;
  logic acked;
  logic push;
  logic pop;
  logic head_id;

  assign fifo_full  = (count == CNT_W'(RD_FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // A read cannot be tracked while the ID FIFO is full, so it is hidden from arbitration.
  assign elig0 = m0_req_i & (m0_we_i | ~fifo_full);
  assign elig1 = m1_req_i & (m1_we_i | ~fifo_full);

  always_comb begin
    winner = 1'b0;
    if (elig0 && elig1) begin
      winner = M1_FIRST ? 1'b1 : ~last_grant;
    end else if (elig1) begin
      winner = 1'b1;
    end
  end

  assign sel     = (state == ST_LOCKED) ? owner : winner;
  assign bus_req = (state == ST_LOCKED) ? (owner ? m1_req_i : m0_req_i)
                                        : (elig0 | elig1);

  always_comb begin
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (bus_req) begin
      if (sel) begin
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_be_o    = m1_be_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_be_o    = m0_be_i;
        s_wdata_o = m0_wdata_i;
      end
    end
  end

  assign s_req_o  = bus_req;
  assign acked    = bus_req & s_ack_i;
  assign m0_ack_o = acked & ~sel;
  assign m1_ack_o = acked & sel;

  assign push    = acked & ~s_we_o;
  assign pop     = s_resp_i & ~fifo_empty;
  assign head_id = id_mem[rd_ptr];

  assign m0_resp_o  = pop & ~head_id;
  assign m1_resp_o  = pop & head_id;
  assign m0_rdata_o = m0_resp_o ? s_rdata_i : '0;
  assign m1_rdata_o = m1_resp_o ? s_rdata_i : '0;

  assign rd_pending_o = count;
  assign err_o        = err;

  // Lock holds the slave fields stable across a stalled request.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus_req && !s_ack_i) begin
            state <= ST_LOCKED;
            owner <= sel;
          end
        end
        ST_LOCKED: begin
          if (s_ack_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (acked) begin
        last_grant <= sel;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      id_mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= sel;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (s_resp_i && fifo_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sigma_bus_arbiter.md
# sigma_bus_arbiter

Two-master, one-slave request/ack/resp arbiter that shares the sigma system bus (RAM and CSR space, e.g. 0x00000000 RAM, 0x80000000 LED CSR) between the CPU data port (master 0) and the UDM debug bridge (master 1). It sits in front of the existing bus splitter. It serialises requests with round-robin or fixed priority and tracks outstanding reads in order. It then routes each read response back to the master that issued it.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- RD_FIFO_DEPTH, 4, max outstanding reads; power of two, ≥2
- PRIORITY, "ROUND_ROBIN", or "M1_FIRST" (UDM always wins ties)

- clk_i  in  1  system clock
- arst_i  in  1  asynchronous reset, active-high
- m0_req_i / m1_req_i  in  1  master request; held with its fields until the matching ack
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_addr_i / m1_addr_i  in  ADDR_W  address
- m0_be_i / m1_be_i  in  DATA_W/8  byte enables
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data
- m0_ack_o / m1_ack_o  out  1  request accepted this cycle
- m0_resp_o / m1_resp_o  out  1  read data valid, one-cycle pulse
- m0_rdata_o / m1_rdata_o  out  DATA_W  read data, valid with resp
- s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o  out  1/1/ADDR_W/DATA_W/8/DATA_W  slave request
- s_ack_i  in  1  slave accepted s_req_o
- s_resp_i  in  1  slave read response, in order
- s_rdata_i  in  DATA_W  slave read data
- rd_pending_o  out  $clog2(RD_FIFO_DEPTH)+1  outstanding read count
- err_o  out  1  sticky: s_resp_i arrived with no outstanding read

## Operation

- Arbitration uses two states. In IDLE, the winner is chosen combinationally from the current requests. In LOCKED, the owner register holds the winner.
- IDLE → LOCKED when s_req_o=1 and s_ack_i=0. LOCKED → IDLE on s_ack_i. An ack in the same cycle as the grant stays in IDLE.
- While LOCKED, the mux selects the owner regardless of other requests, so slave fields stay stable until ack.
- s_ack_i is forwarded to the owner's ack only. The other master's ack stays 0.
- Round-robin: when both request in IDLE, grant the master not granted last. last_grant updates on every ack.
- M1_FIRST: m1 wins every tie.
- Read tracking: on an acked read, push the owner id into the ID FIFO.
- On s_resp_i, pop the head id and assert that master's resp with rdata = s_rdata_i.
- The rdata of the non-selected master is forced to 0.
- Push and pop in the same cycle are both performed; the count is unchanged.
- FIFO full: read requests are masked from arbitration, so their ack stays 0. Writes still arbitrate normally. A masked read never enters LOCKED.
- s_resp_i with the FIFO empty: no master resp, err_o set until reset.
- The slave write path carries no response. Writes complete on ack.

## Timing

- Request path is combinational: m*_req_i → s_req_o in the same cycle, zero added latency. s_ack_i → m*_ack_o is combinational.
- Response path is combinational: s_resp_i → m*_resp_o in the same cycle. The ID FIFO head is registered state.
- Back-to-back: a new grant can occur the cycle after an ack. With both masters requesting continuously under ROUND_ROBIN and an always-ack slave, grants alternate m0, m1, m0, ...
- Reset values: state IDLE, last_grant=1 (m0 wins the first tie), FIFO empty, rd_pending_o=0, err_o=0. All acks, resps and s_req_o are 0; all data outputs are 0.
- Reset mid-transaction: the lock and all tracked reads are discarded immediately. Masters must reissue.

## Test plan

- **Single master:** m1 writes 0xdeadbeef to 0x80000000, slave acks on the 3rd cycle. Required: s_* stable for 3 cycles, m1_ack_o pulses once, m0_ack_o=0.
- **Contention, round-robin:** both masters read continuously, slave always acks with resp 2 cycles later.
  - Grants alternate m0, m1 starting with m0.
  - Each rdata returns to its issuer in order.
  - rd_pending_o peaks at 2.
- **Lock:** m0 requests and the slave stalls 5 cycles. m1 asserts during the stall. Required: s_addr_o stays m0's until ack, then m1 is granted the next cycle.
- **FIFO full:** RD_FIFO_DEPTH=4, 4 reads acked, no responses yet.
  - A 5th read gets no ack.
  - A concurrent write from the other master is acked.
  - After one s_resp_i, the 5th read is acked.
- **Error and reset:**
  - s_resp_i with the FIFO empty → err_o=1, no resp asserted.
  - Assert arst_i with 2 reads pending → rd_pending_o=0, err_o=0.
  - Re-issued reads then complete normally.
